// File: rtl/branch_compare_if.sv
// rtl/branch_compare_if.sv - handshake bundle between the issue side and branch_compare_pipe
interface branch_compare_if #(parameter int WIDTH = 16);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       cond;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       rel;
    logic             taken;
    logic [15:0]      taken_cnt;

    modport master (
        output in_valid, a, b, cond, flush, out_ready,
        input  in_ready, out_valid, rel, taken, taken_cnt
    );

    modport slave (
        input  in_valid, a, b, cond, flush, out_ready,
        output in_ready, out_valid, rel, taken, taken_cnt
    );
endinterface

// File: rtl/branch_compare_pipe.sv
// rtl/branch_compare_pipe.sv - pipelined signed/unsigned branch comparator with flush
// Optional taken-branch counter enabled by BRANCH_COMPARE_STATS_EN.
module branch_compare_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 1
) (
    input logic             clk,
    input logic             rst_n,
    branch_compare_if.slave bus
);
    localparam int HALF = WIDTH / 2;

    function automatic logic [1:0] rel_of(input logic eq, input logic lt);
        return eq ? 2'b00 : (lt ? 2'b01 : 2'b10);
    endfunction

    function automatic logic taken_of(input logic [2:0] c, input logic [1:0] r);
        logic t;
        case (c)
            3'b000:         t = (r == 2'b00);
            3'b001:         t = (r != 2'b00);
            3'b010, 3'b100: t = (r == 2'b01);
            3'b011, 3'b101: t = (r != 2'b01);
            3'b110:         t = 1'b1;
            default:        t = 1'b0;
        endcase
        return t;
    endfunction

    logic       advance;
    logic       fin_valid;
    logic [1:0] fin_rel;
    logic       fin_taken;

    assign advance      = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = advance && !bus.flush;

    generate
        if (STAGES == 1) begin : g_single
            logic [WIDTH-1:0] mask;
            always_comb begin
                mask            = '0;
                mask[WIDTH-1]   = !bus.cond[2];
                fin_valid       = bus.in_valid;
                fin_rel         = rel_of(bus.a == bus.b, (bus.a ^ mask) < (bus.b ^ mask));
                fin_taken       = taken_of(bus.cond, fin_rel);
            end
        end else begin : g_split
            logic            s1_valid_q, s1_valid_d;
            logic            hi_eq_q, hi_eq_d, hi_lt_q, hi_lt_d;
            logic            lo_eq_q, lo_eq_d, lo_lt_q, lo_lt_d;
            logic [2:0]      cond_q, cond_d;
            logic [HALF-1:0] hi_mask, a_hi, b_hi;
            logic [1:0]      comb_rel;
            logic            comb_taken;

            // Flipping the high-half MSB turns a signed compare into an unsigned one.
            always_comb begin
                hi_mask         = '0;
                hi_mask[HALF-1] = !bus.cond[2];
                a_hi            = bus.a[WIDTH-1:HALF] ^ hi_mask;
                b_hi            = bus.b[WIDTH-1:HALF] ^ hi_mask;
                s1_valid_d      = bus.flush ? 1'b0 : (advance ? bus.in_valid : s1_valid_q);
                hi_eq_d         = hi_eq_q;
                hi_lt_d         = hi_lt_q;
                lo_eq_d         = lo_eq_q;
                lo_lt_d         = lo_lt_q;
                cond_d          = cond_q;
                if (advance) begin
                    hi_eq_d = (a_hi == b_hi);
                    hi_lt_d = (a_hi < b_hi);
                    lo_eq_d = (bus.a[HALF-1:0] == bus.b[HALF-1:0]);
                    lo_lt_d = (bus.a[HALF-1:0] < bus.b[HALF-1:0]);
                    cond_d  = bus.cond;
                end
                comb_rel   = rel_of(hi_eq_q & lo_eq_q, hi_lt_q | (hi_eq_q & lo_lt_q));
                comb_taken = taken_of(cond_q, comb_rel);
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_valid_q <= 1'b0;
                    hi_eq_q    <= 1'b0;
                    hi_lt_q    <= 1'b0;
                    lo_eq_q    <= 1'b0;
                    lo_lt_q    <= 1'b0;
                    cond_q     <= 3'b000;
                end else begin
                    s1_valid_q <= s1_valid_d;
                    hi_eq_q    <= hi_eq_d;
                    hi_lt_q    <= hi_lt_d;
                    lo_eq_q    <= lo_eq_d;
                    lo_lt_q    <= lo_lt_d;
                    cond_q     <= cond_d;
                end
            end

            if (STAGES == 2) begin : g_two
                always_comb begin
                    fin_valid = s1_valid_q;
                    fin_rel   = comb_rel;
                    fin_taken = comb_taken;
                end
            end else begin : g_three
                logic       s2_valid_q, s2_valid_d;
                logic [1:0] s2_rel_q, s2_rel_d;
                logic       s2_taken_q, s2_taken_d;

                always_comb begin
                    s2_valid_d = bus.flush ? 1'b0 : (advance ? s1_valid_q : s2_valid_q);
                    s2_rel_d   = advance ? comb_rel   : s2_rel_q;
                    s2_taken_d = advance ? comb_taken : s2_taken_q;
                    fin_valid  = s2_valid_q;
                    fin_rel    = s2_rel_q;
                    fin_taken  = s2_taken_q;
                end

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        s2_valid_q <= 1'b0;
                        s2_rel_q   <= 2'b00;
                        s2_taken_q <= 1'b0;
                    end else begin
                        s2_valid_q <= s2_valid_d;
                        s2_rel_q   <= s2_rel_d;
                        s2_taken_q <= s2_taken_d;
                    end
                end
            end
        end
    endgenerate

    logic       out_valid_q, out_valid_d;
    logic [1:0] rel_q, rel_d;
    logic       taken_q, taken_d;

    always_comb begin
        out_valid_d = bus.flush ? 1'b0 : (advance ? fin_valid : out_valid_q);
        rel_d       = advance ? fin_rel   : rel_q;
        taken_d     = advance ? fin_taken : taken_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            rel_q       <= 2'b00;
            taken_q     <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            rel_q       <= rel_d;
            taken_q     <= taken_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.rel       = rel_q;
    assign bus.taken     = taken_q;

`ifdef BRANCH_COMPARE_STATS_EN
    logic [15:0] cnt_q, cnt_d;

    // A flushed result is dropped, so it never counts as consumed.
    always_comb begin
        cnt_d = cnt_q;
        if (out_valid_q && bus.out_ready && !bus.flush && taken_q)
            cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= 16'h0000;
        else        cnt_q <= cnt_d;
    end

    assign bus.taken_cnt = cnt_q;
`else
    assign bus.taken_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_branch_compare_pipe.sv
// tb/tb_branch_compare_pipe.sv - scoreboard bench for branch_compare_pipe at STAGES 1, 2 and 3
module tb_branch_compare_pipe;
    localparam logic [2:0] C_EQ = 3'b000, C_NE = 3'b001, C_LT = 3'b010, C_GE = 3'b011;
    localparam logic [2:0] C_LTU = 3'b100, C_GEU = 3'b101, C_ALW = 3'b110, C_NEV = 3'b111;

    typedef struct packed {
        logic [1:0]  rel;
        logic        taken;
        logic        strict;
        int unsigned cyc;
    } item_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic [2:0]  cond = '0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b1;
    logic        strict = 1'b0;
    int unsigned cyc = 0;
    int          n_total = 0;
    int          n_bad = 0;

    logic        ov[3];
    logic        ir[3];
    logic [1:0]  rl[3];
    logic        tk[3];
    logic [15:0] tc[3];
    logic [15:0] ecnt[3];
    int          qs[3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] ref_rel(input logic [15:0] x, input logic [15:0] y, input logic [2:0] c);
        if (x == y) return 2'b00;
        if (c[2] ? (x < y) : ($signed(x) < $signed(y))) return 2'b01;
        return 2'b10;
    endfunction

    function automatic logic ref_taken(input logic [2:0] c, input logic [1:0] r);
        case (c)
            C_EQ:          return r == 2'b00;
            C_NE:          return r != 2'b00;
            C_LT, C_LTU:   return r == 2'b01;
            C_GE, C_GEU:   return r != 2'b01;
            C_ALW:         return 1'b1;
            default:       return 1'b0;
        endcase
    endfunction

    for (genvar gi = 0; gi < 3; gi++) begin : g
        localparam int S = gi + 1;
        branch_compare_if #(.WIDTH(16)) bus ();
        item_t       q[$];
        item_t       e;
        logic        stall_v = 1'b0;
        logic        prev_flush = 1'b0;
        logic [1:0]  hold_rel = '0;
        logic        hold_taken = 1'b0;
        logic [15:0] exp_cnt = '0;
        int          qsize = 0;

        assign bus.in_valid  = in_valid;
        assign bus.a         = a;
        assign bus.b         = b;
        assign bus.cond      = cond;
        assign bus.flush     = flush;
        assign bus.out_ready = out_ready;
        assign ov[gi]   = bus.out_valid;
        assign ir[gi]   = bus.in_ready;
        assign rl[gi]   = bus.rel;
        assign tk[gi]   = bus.taken;
        assign tc[gi]   = bus.taken_cnt;
        assign ecnt[gi] = exp_cnt;
        assign qs[gi]   = qsize;

        branch_compare_pipe #(.WIDTH(16), .STAGES(S)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus.slave)
        );

        always @(negedge clk) begin
            if (!rst_n) begin
                q.delete();
                stall_v    = 1'b0;
                prev_flush = 1'b0;
                exp_cnt    = '0;
            end else begin
                if (prev_flush) check($sformatf("s%0d_flush_ov", S), bus.out_valid, 1'b0);
                if (stall_v) begin
                    check($sformatf("s%0d_hold_rel", S), bus.rel, hold_rel);
                    check($sformatf("s%0d_hold_taken", S), bus.taken, hold_taken);
                end
                if (flush) begin
                    q.delete();
                end else begin
                    if (bus.out_valid && out_ready) begin
                        if (q.size() == 0) begin
                            check($sformatf("s%0d_unexpected_out", S), 1'b1, 1'b0);
                        end else begin
                            e = q.pop_front();
                            check($sformatf("s%0d_rel", S), bus.rel, e.rel);
                            check($sformatf("s%0d_taken", S), bus.taken, e.taken);
                            if (e.strict && strict)
                                check($sformatf("s%0d_latency", S), cyc - e.cyc, S);
                            else
                                check($sformatf("s%0d_latency_min", S), (cyc - e.cyc) >= S, 1'b1);
                            if (e.taken) exp_cnt = exp_cnt + 16'd1;
                        end
                    end
                    if (in_valid && bus.in_ready) begin
                        e.rel    = ref_rel(a, b, cond);
                        e.taken  = ref_taken(cond, e.rel);
                        e.strict = strict;
                        e.cyc    = cyc;
                        q.push_back(e);
                    end
                end
                stall_v    = bus.out_valid && !out_ready && !flush;
                hold_rel   = bus.rel;
                hold_taken = bus.taken;
                prev_flush = flush;
            end
            qsize = q.size();
        end
    end

    task automatic cyc1(input logic v, input logic [15:0] aa, input logic [15:0] bb,
                        input logic [2:0] cc, input logic fl, input logic rdy);
        in_valid  = v;
        a         = aa;
        b         = bb;
        cond      = cc;
        flush     = fl;
        out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        int left;
        left = budget;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        do begin
            @(posedge clk);
            #1;
            left--;
        end while ((qs[0] + qs[1] + qs[2]) != 0 && left > 0);
        check("drain_empty", qs[0] + qs[1] + qs[2], 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s_s%0d_ov", tag, i + 1), ov[i], 1'b0);
            check($sformatf("%s_s%0d_rel", tag, i + 1), rl[i], 2'b00);
            check($sformatf("%s_s%0d_taken", tag, i + 1), tk[i], 1'b0);
            check($sformatf("%s_s%0d_cnt", tag, i + 1), tc[i], 16'h0000);
        end
    endtask

    logic [15:0] corner[8];
    logic [2:0]  dir_c[8];

    initial begin
        corner = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h00FF, 16'hFF00, 16'h0100};
        dir_c  = '{C_EQ, C_NE, C_LT, C_GE, C_LTU, C_GEU, C_ALW, C_NEV};

        #3;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) check($sformatf("reset_s%0d_in_ready", i + 1), ir[i], 1'b1);

        // directed compares at full rate
        strict = 1'b1;
        cyc1(1, 16'd5, 16'd32, C_LT, 0, 1);
        check("tp1_ov", ov[0], 1'b1);
        check("tp1_rel", rl[0], 2'b01);
        check("tp1_taken", tk[0], 1'b1);
        cyc1(1, 16'd10, 16'd6, C_LT, 0, 1);
        check("tp1b_rel", rl[0], 2'b10);
        check("tp1b_taken", tk[0], 1'b0);
        cyc1(1, 16'hFFFF, 16'h0001, C_LT, 0, 1);
        check("tp2_lt_rel", rl[0], 2'b01);
        check("tp2_lt_taken", tk[0], 1'b1);
        cyc1(1, 16'hFFFF, 16'h0001, C_LTU, 0, 1);
        check("tp2_ltu_rel", rl[0], 2'b10);
        check("tp2_ltu_taken", tk[0], 1'b0);
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                cyc1(1, corner[i], corner[j], dir_c[(i + j) % 8], 0, 1);
        drain(20);
        strict = 1'b0;

        // back-to-back equal compares with a 3-cycle output stall
        for (int k = 0; k < 11; k++)
            cyc1(1, 16'h0001, 16'h0001, C_EQ, 0, !(k >= 4 && k < 7));
        drain(20);

        // flush with compares in flight and a new one presented
        cyc1(1, 16'd1, 16'd2, C_LT, 0, 1);
        cyc1(1, 16'd3, 16'd2, C_GE, 0, 1);
        in_valid = 1'b1;
        flush    = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) check($sformatf("flush_s%0d_in_ready", i + 1), ir[i], 1'b0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) check($sformatf("flush_s%0d_ov_next", i + 1), ov[i], 1'b0);
        drain(20);

        // random traffic with stalls and occasional flushes
        for (int k = 0; k < 400; k++)
            cyc1($urandom_range(3, 0) != 0,
                 ($urandom_range(1, 0) != 0) ? corner[$urandom_range(7, 0)] : 16'($urandom),
                 ($urandom_range(1, 0) != 0) ? corner[$urandom_range(7, 0)] : 16'($urandom),
                 3'($urandom_range(7, 0)),
                 $urandom_range(40, 0) == 0,
                 $urandom_range(9, 0) < 7);
        drain(30);

        for (int i = 0; i < 3; i++) begin
`ifdef BRANCH_COMPARE_STATS_EN
            check($sformatf("cnt_s%0d", i + 1), tc[i], ecnt[i]);
`else
            check($sformatf("cnt_s%0d", i + 1), tc[i], 16'h0000);
`endif
        end

        // asynchronous reset with results waiting at the output
        cyc1(1, 16'h0005, 16'h0005, C_ALW, 0, 0);
        cyc1(1, 16'h0006, 16'h0005, C_ALW, 0, 0);
        cyc1(1, 16'h0007, 16'h0005, C_ALW, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++)
            cyc1(1, 16'(k * 4000), 16'h4000, dir_c[k], 0, 1);
        drain(20);

`ifdef BRANCH_COMPARE_STATS_EN
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 65535; k++)
            cyc1(1, 16'h0000, 16'h0000, C_ALW, 0, 1);
        drain(20);
        check("cnt_preload", tc[0], 16'hFFFF);
        cyc1(1, 16'h0000, 16'h0000, C_ALW, 0, 1);
        drain(20);
        for (int i = 0; i < 3; i++) check($sformatf("cnt_wrap_s%0d", i + 1), tc[i], 16'h0000);
`else
        for (int i = 0; i < 3; i++) check($sformatf("cnt_off_s%0d", i + 1), tc[i], 16'h0000);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
